// File: rtl/cineraria_core_nios2_fast_cpu_div_cell.sv
// Iterative restoring radix-2 divider for Nios II div/divu.
// Retires one quotient bit per clock, then applies a one-cycle sign fixup.
module cineraria_core_nios2_fast_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_div_start,
    input  logic             E_ctrl_div_signed,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             M_div_kill,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem
);

    // state | meaning
    // IDLE  | waiting for start; done pulses here for one cycle after FIX
    // CALC  | one restoring subtract per clock, WIDTH cycles
    // FIX   | sign fixup and result register
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] src1_raw;
    logic             quot_neg;
    logic             rem_neg;
    logic             div_zero;

    logic             src1_neg;
    logic             src2_neg;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        src1_neg = E_ctrl_div_signed & E_src1[WIDTH-1];
        src2_neg = E_ctrl_div_signed & E_src2[WIDTH-1];
        abs1     = src1_neg ? -E_src1 : E_src1;
        abs2     = src2_neg ? -E_src2 : E_src2;
    end

    // Shifted partial remainder minus divisor; the extra top bit is the borrow.
    always_comb begin
        diff   = {prem, dvd[WIDTH-1]} - {2'b00, dvs};
        borrow = diff[WIDTH+1];
    end

    // Divide-by-zero overrides the arithmetic result with all-ones / raw dividend.
    always_comb begin
        quot_fix = quot_neg ? -dvd : dvd;
        rem_fix  = rem_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
        if (div_zero) begin
            quot_fix = '1;
            rem_fix  = src1_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            prem       <= '0;
            dvd        <= '0;
            dvs        <= '0;
            src1_raw   <= '0;
            quot_neg   <= 1'b0;
            rem_neg    <= 1'b0;
            div_zero   <= 1'b0;
            M_div_busy <= 1'b0;
            M_div_done <= 1'b0;
            M_div_quot <= '0;
            M_div_rem  <= '0;
        end else begin
            M_div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (E_div_start) begin
                        dvd        <= abs1;
                        dvs        <= abs2;
                        src1_raw   <= E_src1;
                        quot_neg   <= src1_neg ^ src2_neg;
                        rem_neg    <= src1_neg;
                        div_zero   <= (E_src2 == '0);
                        prem       <= '0;
                        counter    <= CW'(WIDTH - 1);
                        state      <= CALC;
                        M_div_busy <= 1'b1;
                    end
                end
                CALC: begin
                    if (M_div_kill) begin
                        state      <= IDLE;
                        M_div_busy <= 1'b0;
                    end else begin
                        if (!borrow) begin
                            prem <= diff[WIDTH:0];
                            dvd  <= {dvd[WIDTH-2:0], 1'b1};
                        end else begin
                            prem <= {prem[WIDTH-1:0], dvd[WIDTH-1]};
                            dvd  <= {dvd[WIDTH-2:0], 1'b0};
                        end
                        if (counter == '0) begin
                            state <= FIX;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                end
                FIX: begin
                    state      <= IDLE;
                    M_div_busy <= 1'b0;
                    if (!M_div_kill) begin
                        M_div_quot <= quot_fix;
                        M_div_rem  <= rem_fix;
                        M_div_done <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    M_div_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cineraria_core_nios2_fast_cpu_div_cell.sv
// Directed bench for the radix-2 divider: vector table plus kill/reset/back-to-back sequences.
module tb_cineraria_core_nios2_fast_cpu_div_cell;
    localparam int W = 32;
    localparam int LAT = W + 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          sgn;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic          kill;
    logic          busy;
    logic          done;
    logic [W-1:0]  quot;
    logic [W-1:0]  rem;

    int checks = 0;
    int errors = 0;

    cineraria_core_nios2_fast_cpu_div_cell #(.WIDTH(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .E_div_start       (start),
        .E_ctrl_div_signed (sgn),
        .E_src1            (src1),
        .E_src2            (src2),
        .M_div_kill        (kill),
        .M_div_busy        (busy),
        .M_div_done        (done),
        .M_div_quot        (quot),
        .M_div_rem         (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic         sg;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drive a start request in the current cycle (caller is at a negedge).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        src1  = a;
        src2  = b;
        sgn   = s;
        start = 1'b1;
    endtask

    // Count cycles from the start cycle until done; scramble operands after start.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            kill  = 1'b0;
            src1  = $urandom;
            src2  = $urandom;
            sgn   = $urandom_range(0, 1);
            if (busy !== (lat <= LAT - 1)) busy_ok = 1'b0;
            if (done) break;
        end
    endtask

    int       lat;
    logic     busy_ok;
    int       d1;
    int       d2;
    logic [W-1:0] q1, r1, q2, r2;

    initial begin
        vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,  1'b1, 32'hFFFFFFF2,  32'd2};
        vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0};
        vecs[4]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0};
        vecs[5]  = '{32'h00001234,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h00001234};
        vecs[6]  = '{32'hFFFFFFF0,  32'd0,         1'b1, 32'hFFFFFFFF,  32'hFFFFFFF0};
        vecs[7]  = '{32'd7,         32'd100,       1'b0, 32'd0,         32'd7};
        vecs[8]  = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF};
        vecs[9]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 32'd14,        32'hFFFFFFFE};
        vecs[10] = '{32'hFFFFFFFF,  32'h10,        1'b0, 32'h0FFFFFFF,  32'hF};
        vecs[11] = '{32'hFFFFFF9C,  32'd7,         1'b0, 32'h24924916,  32'd2};
        vecs[12] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000};

        reset = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        src1  = '0;
        src2  = '0;
        kill  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quot", quot, 32'd0);
        check("reset_rem", rem, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            launch(vecs[i].s1, vecs[i].s2, vecs[i].sg);
            wait_done(lat, busy_ok);
            check($sformatf("vec%0d_lat", i), lat, LAT);
            check($sformatf("vec%0d_quot", i), quot, vecs[i].q);
            check($sformatf("vec%0d_rem", i), rem, vecs[i].r);
            check($sformatf("vec%0d_busy", i), {31'd0, busy_ok}, 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // Kill at cycle 10: abort, hold previous results, restart at cycle 11.
        @(negedge clk);
        launch(32'd50, 32'd3, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) kill = 1'b1;
        end
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_done", {31'd0, done}, 32'd0);
        check("kill_quot_held", quot, vecs[12].q);
        check("kill_rem_held", rem, vecs[12].r);
        launch(32'd50, 32'd3, 1'b0);
        wait_done(lat, busy_ok);
        check("restart_lat", lat, LAT);
        check("restart_quot", quot, 32'd16);
        check("restart_rem", rem, 32'd2);

        // Kill together with start in IDLE: start wins.
        @(negedge clk);
        launch(32'd20, 32'd4, 1'b0);
        kill = 1'b1;
        wait_done(lat, busy_ok);
        check("killstart_lat", lat, LAT);
        check("killstart_quot", quot, 32'd5);
        check("killstart_rem", rem, 32'd0);

        // Start held high: back-to-back ops, starts during busy ignored.
        @(negedge clk);
        launch(32'd1000, 32'd10, 1'b0);
        d1 = -1;
        d2 = -1;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int c = 1; c <= 73; c++) begin
            @(negedge clk);
            if (c == 1) begin
                src1 = 32'd77;
                src2 = 32'd5;
            end
            if (c == 70) start = 1'b0;
            if (done && d1 < 0) begin
                d1 = c; q1 = quot; r1 = rem;
            end else if (done && d2 < 0) begin
                d2 = c; q2 = quot; r2 = rem;
            end
            if (c == 73) reset = 1'b1;
        end
        check("b2b_done1_cycle", d1, 34);
        check("b2b_quot1", q1, 32'd100);
        check("b2b_rem1", r1, 32'd0);
        check("b2b_done2_cycle", d2, 68);
        check("b2b_quot2", q2, 32'd15);
        check("b2b_rem2", r2, 32'd2);

        // Reset 5 cycles into the third operation clears everything.
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_quot", quot, 32'd0);
        check("midreset_rem", rem, 32'd0);

        @(negedge clk);
        launch(32'd100, 32'd7, 1'b0);
        wait_done(lat, busy_ok);
        check("recover_lat", lat, LAT);
        check("recover_quot", quot, 32'd14);
        check("recover_rem", rem, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
